// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter
//   Round-robin arbiter that merges N_CH producer streams onto one 32-bit
//   TX stream. Each granted segment is framed as header, data, trailer so
//   the host can demultiplex channels and detect split or lost segments.
//
// Ports
//   clk        system clock (also the USB controller tx clock)
//   rstn       synchronous active-low reset
//   in_valid   per-channel word valid
//   in_ready   per-channel word accept (combinational)
//   in_data    channel c on bits [32c+31:32c]
//   in_last    per-channel end-of-packet marker
//   out_valid  word valid towards the controller
//   out_ready  controller accept
//   out_data   registered output word
//   grant      one-hot owner of the stream, 0 while idle
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no owner; pick next requester round-robin, emit header
// DATA   | forward words of the granted channel
// TRL    | segment closed; load trailer once the output register frees
// WAIT   | trailer pending; on accept bump seq/cont and release grant

module usb_tx_arbiter #(
  parameter int N_CH      = 4,
  parameter int MAX_BURST = 256
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_CH-1:0]      in_valid,
  output logic [N_CH-1:0]      in_ready,
  input  logic [32*N_CH-1:0]   in_data,
  input  logic [N_CH-1:0]      in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic [N_CH-1:0]      grant
);

  localparam int          IDX_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [15:0] BURST_LAST = 16'(MAX_BURST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_TRL  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t state, state_d;

  // last_grant doubles as the active channel index while a segment runs
  logic [IDX_W-1:0] last_grant;
  logic [15:0]      cnt;
  logic             end_last;
  logic [7:0]       seq [N_CH];
  logic [N_CH-1:0]  cont;

  logic             req_any;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] idx;
  logic [3:0]       pick4;
  logic [3:0]       g4;
  logic             out_free;
  logic             in_xfer;
  logic             seg_end;
  logic [31:0]      cur_data;
  logic [31:0]      hdr_word;
  logic [31:0]      trl_word;

  // Scan starts one past the previous owner so every requester gets a turn.
  always_comb begin
    req_any = 1'b0;
    pick    = last_grant;
    idx     = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = IDX_W'((int'(last_grant) + i) % N_CH);
      if (!req_any && in_valid[idx]) begin
        req_any = 1'b1;
        pick    = idx;
      end
    end
  end

  always_comb begin
    pick4                = '0;
    pick4[IDX_W-1:0]     = pick;
    g4                   = '0;
    g4[IDX_W-1:0]        = last_grant;
  end

  assign out_free = !out_valid || out_ready;
  assign in_xfer  = (state == S_DATA) && in_valid[last_grant] && out_free;
  assign seg_end  = in_last[last_grant] || ((cnt + 16'd1) == BURST_LAST);
  assign cur_data = in_data[{last_grant, 5'b00000} +: 32];
  assign hdr_word = {8'hA5, pick4, cont[pick], 3'b000, seq[pick], 8'h00};
  assign trl_word = {8'h5A, g4, end_last, 3'b000, cnt};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (req_any)            state_d = S_DATA;
      S_DATA: if (in_xfer && seg_end) state_d = S_TRL;
      S_TRL:  if (out_free)           state_d = S_WAIT;
      S_WAIT: if (out_ready)          state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  // Ready follows the output register so backpressure reaches the producer
  // in the same cycle.
  always_comb begin
    in_ready = '0;
    if (state == S_DATA) begin
      in_ready[last_grant] = out_free;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      grant      <= '0;
      last_grant <= IDX_W'(N_CH - 1);
      cnt        <= '0;
      end_last   <= 1'b0;
      cont       <= '0;
      for (int i = 0; i < N_CH; i++) begin
        seq[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (req_any) begin
            out_data   <= hdr_word;
            out_valid  <= 1'b1;
            cnt        <= '0;
            last_grant <= pick;
            grant      <= N_CH'(1) << pick;
          end
        end
        S_DATA: begin
          if (in_xfer) begin
            out_data  <= cur_data;
            out_valid <= 1'b1;
            cnt       <= cnt + 16'd1;
            if (seg_end) begin
              end_last <= in_last[last_grant];
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        S_TRL: begin
          if (out_free) begin
            out_data  <= trl_word;
            out_valid <= 1'b1;
          end
        end
        S_WAIT: begin
          if (out_ready) begin
            out_valid        <= 1'b0;
            grant            <= '0;
            seq[last_grant]  <= seq[last_grant] + 8'd1;
            cont[last_grant] <= !end_last;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Bench for usb_tx_arbiter (N_CH=4, MAX_BURST=4).
// Stimulus pushes producer words into per-channel queues and expected
// output words into a scoreboard; a monitor pops and compares on every
// accepted output word. The random-traffic phase uses a per-channel
// framing model instead of an exact word list.

module tb_usb_tx_arbiter;

  localparam int N_CH      = 4;
  localparam int MAX_BURST = 4;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [N_CH-1:0]      in_valid;
  logic [N_CH-1:0]      in_ready;
  logic [32*N_CH-1:0]   in_data;
  logic [N_CH-1:0]      in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_data;
  logic [N_CH-1:0]      grant;

  usb_tx_arbiter #(.N_CH(N_CH), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [32:0] ch_q   [N_CH][$];
  logic [32:0] exp_ch [N_CH][$];
  logic [31:0] exp_q  [$];
  int          acc_cyc[$];

  bit mon_en      = 1'b1;
  bit exact_mode  = 1'b1;
  bit stall_en    = 1'b0;
  bit rand_ready  = 1'b0;
  int flush_cnt   = 0;
  int mon_phase   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", name, got, exp);
  endtask

  // Producer side: presents the head of each channel queue, holds it until
  // accepted, optionally inserts random gaps; also drives out_ready.
  initial begin : producer
    logic [N_CH-1:0] acc;
    logic [32:0]     w;
    int              flush_seen;
    bit              fl;
    bit              hold;
    flush_seen = 0;
    in_valid   = '0;
    in_data    = '0;
    in_last    = '0;
    out_ready  = 1'b1;
    forever begin
      @(negedge clk);
      acc = in_valid & in_ready & {N_CH{rstn}};
      @(posedge clk);
      #1;
      out_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      fl         = (flush_cnt != flush_seen);
      flush_seen = flush_cnt;
      for (int c = 0; c < N_CH; c++) begin
        if (acc[c]) w = ch_q[c].pop_front();
        if (fl) ch_q[c].delete();
        hold = in_valid[c] && !acc[c] && !fl;
        if (!hold) begin
          if (ch_q[c].size() > 0 && (!stall_en || $urandom_range(0, 2) != 0)) begin
            w                  = ch_q[c][0];
            in_valid[c]        = 1'b1;
            in_data[32*c +: 32] = w[31:0];
            in_last[c]         = w[32];
          end else begin
            in_valid[c] = 1'b0;
          end
        end
      end
    end
  end

  initial begin : monitor
    logic [32:0] e;
    logic [31:0] d;
    int          cur;
    int          seg_cnt;
    logic        seg_last;
    logic [7:0]  m_seq  [N_CH];
    logic        m_cont [N_CH];
    int          cyc;
    cyc      = 0;
    cur      = 0;
    seg_cnt  = 0;
    seg_last = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      m_seq[c]  = '0;
      m_cont[c] = 1'b0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        mon_phase = 0;
        for (int c = 0; c < N_CH; c++) begin
          m_seq[c]  = '0;
          m_cont[c] = 1'b0;
        end
      end else if (mon_en && out_valid && out_ready) begin
        acc_cyc.push_back(cyc);
        d = out_data;
        if (exact_mode) begin
          if (exp_q.size() == 0) chk("unexpected_out_word_pending", 32'(exp_q.size()), 32'd1);
          else chk("out_word", d, exp_q.pop_front());
        end else begin
          case (mon_phase)
            0: begin
              cur = int'(d[23:20]);
              chk("hdr_tag", 32'(d[31:24]), 32'h0000_00A5);
              chk("hdr_ch_range", 32'(cur < N_CH), 32'd1);
              if (cur >= N_CH) cur = 0;
              chk("hdr_grant", 32'(grant), 32'(1 << cur));
              chk("hdr_seq", 32'(d[15:8]), 32'(m_seq[cur]));
              chk("hdr_cont", 32'(d[19]), 32'(m_cont[cur]));
              chk("hdr_zero", 32'({d[18:16], d[7:0]}), 32'd0);
              seg_cnt   = 0;
              mon_phase = 1;
            end
            1: begin
              chk("payload_avail", 32'(exp_ch[cur].size() > 0), 32'd1);
              if (exp_ch[cur].size() > 0) begin
                e = exp_ch[cur].pop_front();
                chk("payload", d, e[31:0]);
                seg_last = e[32];
              end else begin
                seg_last = 1'b1;
              end
              seg_cnt++;
              if (seg_last || seg_cnt == MAX_BURST) mon_phase = 2;
            end
            default: begin
              chk("trailer", d, {8'h5A, 4'(cur), seg_last, 3'b000, 16'(seg_cnt)});
              m_seq[cur]  = m_seq[cur] + 8'd1;
              m_cont[cur] = !seg_last;
              mon_phase   = 0;
            end
          endcase
        end
      end
    end
  end

  function automatic bit pending();
    pending = (exp_q.size() != 0) || (mon_phase != 0);
    for (int c = 0; c < N_CH; c++) begin
      if (exp_ch[c].size() != 0) pending = 1'b1;
    end
  endfunction

  task automatic push(input int c, input logic [31:0] d, input logic last);
    ch_q[c].push_back({last, d});
  endtask

  task automatic expect_w(input logic [31:0] w);
    exp_q.push_back(w);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    acc_cyc.delete();
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while (pending() && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain_pending"}, 32'(pending()), 32'd0);
    repeat (6) @(negedge clk);
  endtask

  initial begin : main
    int words;
    int len;
    int n;
    logic [31:0] d;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);

    // single channel, then a second packet showing seq advanced
    do_reset();
    push(0, 32'h11, 1'b0);
    push(0, 32'h22, 1'b0);
    push(0, 32'h33, 1'b1);
    push(0, 32'h44, 1'b1);
    expect_w(32'hA500_0000);
    expect_w(32'h0000_0011);
    expect_w(32'h0000_0022);
    expect_w(32'h0000_0033);
    expect_w(32'h5A08_0003);
    expect_w(32'hA500_0100);
    expect_w(32'h0000_0044);
    expect_w(32'h5A08_0001);
    drain("single", 200);
    chk("single_accept_count", 32'(acc_cyc.size()), 32'd8);
    if (acc_cyc.size() >= 6) begin
      chk("single_seg_cycles", 32'(acc_cyc[4] - acc_cyc[0]), 32'd4);
      chk("single_idle_gap", 32'(acc_cyc[5] - acc_cyc[4]), 32'd2);
    end

    // round robin over all channels, 1-word packets
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < N_CH; c++) begin
        d = 32'hC000_0000 | 32'(r * 16 + c);
        push(c, d, 1'b1);
        expect_w({8'hA5, 4'(c), 1'b0, 3'b000, 8'(r), 8'h00});
        expect_w(d);
        expect_w({8'h5A, 4'(c), 1'b1, 3'b000, 16'd1});
      end
    end
    drain("round_robin", 400);

    // 10-word packet on ch2 split into 4,4,2
    do_reset();
    for (int i = 0; i < 10; i++) push(2, 32'h2000 + 32'(i), i == 9);
    expect_w(32'hA520_0000);
    for (int i = 0; i < 4; i++) expect_w(32'h2000 + 32'(i));
    expect_w(32'h5A20_0004);
    expect_w(32'hA528_0100);
    for (int i = 4; i < 8; i++) expect_w(32'h2000 + 32'(i));
    expect_w(32'h5A20_0004);
    expect_w(32'hA528_0200);
    expect_w(32'h0000_2008);
    expect_w(32'h0000_2009);
    expect_w(32'h5A28_0002);
    drain("burst_split", 200);

    // seq wraps after 256 segments
    do_reset();
    for (int i = 0; i < 257; i++) begin
      d = 32'h1000_0000 + 32'(i);
      push(1, d, 1'b1);
      expect_w({8'hA5, 4'd1, 1'b0, 3'b000, 8'(i), 8'h00});
      expect_w(d);
      expect_w(32'h5A18_0001);
    end
    drain("seq_wrap", 5000);

    // reset in the middle of a ch3 segment
    do_reset();
    push(3, 32'h3333_0001, 1'b1);
    expect_w(32'hA530_0000);
    expect_w(32'h3333_0001);
    expect_w(32'h5A38_0001);
    drain("pre_reset", 200);
    mon_en = 1'b0;
    push(3, 32'h3333_1000, 1'b0);
    push(3, 32'h3333_1001, 1'b0);
    push(3, 32'h3333_1002, 1'b1);
    n = 0;
    while (grant != 4'b1000 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reset_grant3", 32'(grant), 32'h8);
    @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    flush_cnt++;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("mid_reset_out_valid", 32'(out_valid), 32'd0);
    chk("mid_reset_grant", 32'(grant), 32'd0);
    chk("mid_reset_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    mon_en = 1'b1;
    push(0, 32'h0000_0A0A, 1'b1);
    push(3, 32'h3333_0002, 1'b1);
    expect_w(32'hA500_0000);
    expect_w(32'h0000_0A0A);
    expect_w(32'h5A08_0001);
    expect_w(32'hA530_0000);
    expect_w(32'h3333_0002);
    expect_w(32'h5A38_0001);
    drain("post_reset", 200);

    // random backpressure and producer gaps on all channels
    do_reset();
    exact_mode = 1'b0;
    stall_en   = 1'b1;
    rand_ready = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      words = 0;
      while (words < 100) begin
        len = $urandom_range(1, 7);
        for (int k = 0; k < len; k++) begin
          d = $urandom;
          push(c, d, k == len - 1);
          exp_ch[c].push_back({k == len - 1, d});
        end
        words += len;
      end
    end
    drain("random", 20000);
    rand_ready = 1'b0;
    stall_en   = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
